id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage for the LEGv8 pipeline. Holds one fetched instruction in an IF/ID slot and drives the regfile read addresses from it.
- Decodes opcode, control signals and immediate. Captures the regfile read data, control and immediate into an ID/EX register for execute.
- Upstream handshake with fetch, downstream handshake with execute. Inserts a one-cycle load-use bubble; supports branch flush.

Parameters:
WORD, 64, datapath width; must match regfile `WORD
PC_W, 64, program-counter width

Ports:
clk  in  1  single pipeline clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  ID slot can accept
in_instr  in  32  instruction word
in_pc  in  PC_W  instruction address
flush  in  1  branch taken in EX; kill ID and ID/EX contents
read_register1  out  5  regfile port 1 address (Rn)
read_register2  out  5  regfile port 2 address (Rm, or Rt when reg2loc)
read_data1  in  WORD  regfile port 1 data, valid same cycle as address
read_data2  in  WORD  regfile port 2 data
out_valid  out  1  ID/EX register holds an instruction
out_ready  in  1  execute accepts
out_pc, out_a, out_b, out_imm  out  PC_W/WORD/WORD/WORD  registered pc, operands, sign-extended immediate
out_rd  out  5  destination (Rd/Rt)
out_ctrl  out  ctrl_t  reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, uncond_branch, alu_op[1:0]
illegal_instr  out  1  one-cycle pulse on issue of an undecodable word

Behaviour:
- Reset (async, rst_n=0): ID slot valid=0, out_valid=0, all out_* registers 0, illegal_instr=0. In-flight instructions are discarded; no partial issue.
- Decoded opcodes:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (R-type, alu_op=10).
  - ADDI 1001000100, SUBI 1101000100 (imm12 [21:10], zero-extended, alu_src=1).
  - LDUR 11111000010, STUR 11111000000 (imm9 [20:12], sign-extended, alu_op=00).
  - CBZ 10110100 (imm19 [23:5], sign-extended, reg2loc, alu_op=01, branch=1).
  - B 000101 (imm26 [25:0], sign-extended, uncond_branch=1).
  - Immediates are not shifted here.
- reg2loc (STUR, CBZ): read_register2=Rt [4:0]; otherwise Rm [20:16]. read_register1=Rn [9:5] always. Read addresses are combinational from the ID slot.
- Illegal opcode: issues as a bubble-equivalent (all ctrl 0). illegal_instr pulses in the issue cycle; out_valid still 1 so EX sees the pc.
- Issue condition: slot_valid and not hazard and (not out_valid or out_ready). On issue, ID/EX captures read_data1/2, imm, ctrl, rd, pc; out_valid<=1.
- If out_valid and out_ready and no issue: out_valid<=0.
- in_ready = not slot_valid or issue. Accept when in_valid and in_ready.
- Latency: accepted at edge N, out_valid at edge N+1 absent stall/backpressure.
- Load-use hazard: the previous edge issued LDUR with Rt≠31, and Rt equals the current Rn, or the current Rm/Rt where that operand is used. Hold the slot exactly one cycle. No issue that cycle, so out_valid drops if EX consumed. Store data (Rt) counts as used.
- Backpressure: out_valid and not out_ready. All out_* hold stable. Slot holds; in_ready=0 once slot full.
- Flush (synchronous): slot_valid<=0 and out_valid<=0. An in_valid in the same cycle is dropped (in_ready ignored). Flush beats issue and accept. The hazard tracker is cleared.
- Width rules: sign extension replicates the top immediate bit to WORD. XZR (31) is passed as an address; the regfile supplies 0.

Decomposition:
- Package decode_pkg:
  - opcode localparams;
  - ctrl_t packed struct;
  - alu_op_t enum (MEM=00, CBZ=01, RTYPE=10);
  - XZR=5'd31.
- Sub-module instr_decoder: combinational instruction word -> ctrl_t, reg2loc, imm, illegal. The stage owns the registers, handshake and hazard logic.

Test Plan:
- ADD X3,X1,X2 (0x8B020023), read_data1=10, read_data2=20:
  - rr1=1, rr2=2;
  - next edge: out_valid=1, out_a=10, out_b=20, out_rd=3, reg_write=1, alu_op=10.
- LDUR X5,[X2,#-8] (0xF85F8045), then ADD X6,X5,X1 (0x8B0100A6):
  - LDUR issues with imm=0xFFFF_FFFF_FFFF_FFF8 and mem_read=1;
  - ADD is held one cycle (one bubble), then issues with rr1=5.
- STUR X7,[X4,#16] (0xF8010087):
  - rr1=4, rr2=7 (reg2loc);
  - out_imm=16, mem_write=1, reg_write=0.
- out_ready=0 for 3 cycles with two instructions pending:
  - out_* stable all 3 cycles;
  - in_ready=0 after the slot fills;
  - issue order is preserved on release.
- flush=1 with in_valid=1 and both slots full: next edge out_valid=0, slot empty, incoming instruction never appears.
- 0x00000000, then rst_n low mid-stall:
  - first: illegal_instr pulse, all ctrl 0;
  - reset: immediate out_valid=0, all outputs 0, in_ready=1 after release.

Source files
------------

// File: rtl/decode_pkg.sv
// LEGv8 decode constants, control bundle and ALU-op encoding shared by
// the ID stage, its decoder and its interface.
package decode_pkg;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [9:0]  OP_SUBI = 10'b1101000100;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [5:0]  OP_B    = 6'b000101;

   localparam logic [4:0]  XZR     = 5'd31;

   typedef enum logic [1:0] {
      ALU_MEM   = 2'b00,
      ALU_CBZ   = 2'b01,
      ALU_RTYPE = 2'b10
   } alu_op_t;

   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    alu_src;
      logic    branch;
      logic    uncond_branch;
      alu_op_t alu_op;
   } ctrl_t;

endpackage

// File: rtl/id_stage_if.sv
// Fetch->decode and decode->execute handshakes of the ID stage.
// slave is the ID stage's view; master is the surrounding pipeline's view.
interface id_stage_if #(
   parameter int WORD = 64,
   parameter int PC_W = 64
);
   import decode_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [WORD-1:0] out_a;
   logic [WORD-1:0] out_b;
   logic [WORD-1:0] out_imm;
   logic [4:0]      out_rd;
   ctrl_t           out_ctrl;
   logic            illegal_instr;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_a, out_b, out_imm,
             out_rd, out_ctrl, illegal_instr
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_a, out_b, out_imm,
             out_rd, out_ctrl, illegal_instr
   );

endinterface

// File: rtl/instr_decoder.sv
// Combinational LEGv8 decoder: instruction word -> control, immediate,
// register-2 source select and operand-usage flags for hazard detection.
module instr_decoder
   import decode_pkg::*;
#(
   parameter int WORD = 64
) (
   input  logic [31:0]     instr,
   output ctrl_t           ctrl,
   output logic            reg2loc,
   output logic            use_rr2,
   output logic [WORD-1:0] imm,
   output logic            illegal
);

   always_comb begin
      ctrl    = '0;
      reg2loc = 1'b0;
      use_rr2 = 1'b0;
      imm     = '0;
      illegal = 1'b0;

      if (instr[31:21] == OP_ADD || instr[31:21] == OP_SUB ||
          instr[31:21] == OP_AND || instr[31:21] == OP_ORR) begin
         ctrl.reg_write = 1'b1;
         ctrl.alu_op    = ALU_RTYPE;
         use_rr2        = 1'b1;
      end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
         // Immediate arithmetic lets EX pick the function from the opcode.
         ctrl.reg_write = 1'b1;
         ctrl.alu_src   = 1'b1;
         ctrl.alu_op    = ALU_RTYPE;
         imm            = {{(WORD-12){1'b0}}, instr[21:10]};
      end else if (instr[31:21] == OP_LDUR) begin
         ctrl.reg_write  = 1'b1;
         ctrl.mem_read   = 1'b1;
         ctrl.mem_to_reg = 1'b1;
         ctrl.alu_src    = 1'b1;
         ctrl.alu_op     = ALU_MEM;
         imm             = {{(WORD-9){instr[20]}}, instr[20:12]};
      end else if (instr[31:21] == OP_STUR) begin
         ctrl.mem_write = 1'b1;
         ctrl.alu_src   = 1'b1;
         ctrl.alu_op    = ALU_MEM;
         reg2loc        = 1'b1;
         use_rr2        = 1'b1;
         imm            = {{(WORD-9){instr[20]}}, instr[20:12]};
      end else if (instr[31:24] == OP_CBZ) begin
         ctrl.branch = 1'b1;
         ctrl.alu_op = ALU_CBZ;
         reg2loc     = 1'b1;
         use_rr2     = 1'b1;
         imm         = {{(WORD-19){instr[23]}}, instr[23:5]};
      end else if (instr[31:26] == OP_B) begin
         ctrl.uncond_branch = 1'b1;
         imm                = {{(WORD-26){instr[25]}}, instr[25:0]};
      end else begin
         illegal = 1'b1;
      end
   end

endmodule

// File: rtl/id_stage.sv
// LEGv8 decode stage: IF/ID slot, regfile addressing, load-use bubble,
// branch flush and the registered ID/EX hand-off to execute.
module id_stage
   import decode_pkg::*;
#(
   parameter int WORD = 64,
   parameter int PC_W = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   output logic [4:0]      read_register1,
   output logic [4:0]      read_register2,
   input  logic [WORD-1:0] read_data1,
   input  logic [WORD-1:0] read_data2,
   id_stage_if.slave       bus
);

   logic            slot_valid_reg;
   logic [31:0]     slot_instr_reg;
   logic [PC_W-1:0] slot_pc_reg;

   logic            out_valid_reg;
   logic [PC_W-1:0] out_pc_reg;
   logic [WORD-1:0] out_a_reg;
   logic [WORD-1:0] out_b_reg;
   logic [WORD-1:0] out_imm_reg;
   logic [4:0]      out_rd_reg;
   ctrl_t           out_ctrl_reg;
   logic            illegal_reg;

   // Destination of a load issued on the previous edge, if any.
   logic            ld_valid_reg;
   logic [4:0]      ld_rt_reg;

   ctrl_t           dec_ctrl;
   logic            dec_reg2loc;
   logic            dec_use_rr2;
   logic [WORD-1:0] dec_imm;
   logic            dec_illegal;

   logic            hazard;
   logic            issue;
   logic            accept;

   instr_decoder #(.WORD(WORD)) u_dec (
      .instr   (slot_instr_reg),
      .ctrl    (dec_ctrl),
      .reg2loc (dec_reg2loc),
      .use_rr2 (dec_use_rr2),
      .imm     (dec_imm),
      .illegal (dec_illegal)
   );

   assign read_register1 = slot_instr_reg[9:5];
   assign read_register2 = dec_reg2loc ? slot_instr_reg[4:0] : slot_instr_reg[20:16];

   // Rn is always compared; the second port only when that operand is consumed.
   assign hazard = ld_valid_reg &&
                   ((ld_rt_reg == read_register1) ||
                    (dec_use_rr2 && (ld_rt_reg == read_register2)));

   assign issue  = slot_valid_reg && !hazard && !flush &&
                   (!out_valid_reg || bus.out_ready);
   assign accept = bus.in_valid && bus.in_ready && !flush;

   assign bus.in_ready      = !slot_valid_reg || issue;
   assign bus.out_valid     = out_valid_reg;
   assign bus.out_pc        = out_pc_reg;
   assign bus.out_a         = out_a_reg;
   assign bus.out_b         = out_b_reg;
   assign bus.out_imm       = out_imm_reg;
   assign bus.out_rd        = out_rd_reg;
   assign bus.out_ctrl      = out_ctrl_reg;
   assign bus.illegal_instr = illegal_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_valid_reg <= 1'b0;
         slot_instr_reg <= '0;
         slot_pc_reg    <= '0;
         out_valid_reg  <= 1'b0;
         out_pc_reg     <= '0;
         out_a_reg      <= '0;
         out_b_reg      <= '0;
         out_imm_reg    <= '0;
         out_rd_reg     <= '0;
         out_ctrl_reg   <= '0;
         illegal_reg    <= 1'b0;
         ld_valid_reg   <= 1'b0;
         ld_rt_reg      <= '0;
      end else if (flush) begin
         slot_valid_reg <= 1'b0;
         out_valid_reg  <= 1'b0;
         illegal_reg    <= 1'b0;
         ld_valid_reg   <= 1'b0;
      end else begin
         if (accept) begin
            slot_valid_reg <= 1'b1;
            slot_instr_reg <= bus.in_instr;
            slot_pc_reg    <= bus.in_pc;
         end else if (issue) begin
            slot_valid_reg <= 1'b0;
         end

         if (issue) begin
            out_valid_reg <= 1'b1;
            out_pc_reg    <= slot_pc_reg;
            out_a_reg     <= read_data1;
            out_b_reg     <= read_data2;
            out_imm_reg   <= dec_imm;
            out_rd_reg    <= slot_instr_reg[4:0];
            out_ctrl_reg  <= dec_ctrl;
         end else if (out_valid_reg && bus.out_ready) begin
            out_valid_reg <= 1'b0;
         end

         illegal_reg  <= issue && dec_illegal;
         ld_valid_reg <= issue && dec_ctrl.mem_read && (slot_instr_reg[4:0] != XZR);
         ld_rt_reg    <= slot_instr_reg[4:0];
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed LEGv8 scenarios followed by
// randomized traffic checked against a field-level decode model.
module tb_id_stage;

   localparam int WORD = 64;
   localparam int PC_W = 64;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] imm;
      logic [4:0]  rd;
      logic [8:0]  ctrl;
      bit          illegal;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [4:0]  rr1;
   logic [4:0]  rr2;
   logic [63:0] rd1;
   logic [63:0] rd2;
   logic [63:0] regs [32];

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   bit          taken = 1'b0;

   id_stage_if #(.WORD(WORD), .PC_W(PC_W)) bus();

   id_stage #(.WORD(WORD), .PC_W(PC_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .read_register1 (rr1),
      .read_register2 (rr2),
      .read_data1     (rd1),
      .read_data2     (rd2),
      .bus            (bus)
   );

   assign rd1 = regs[rr1];
   assign rd2 = regs[rr2];

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w, input logic [63:0] pc);
      bus.in_valid = 1'b1;
      bus.in_instr = w;
      bus.in_pc    = pc;
   endtask

   // Reference decode straight from the instruction-set tables.
   function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
      exp_t   e;
      longint v;
      bit     rw = 0, mr = 0, mw = 0, mtr = 0, as = 0, br = 0, ub = 0, r2l = 0;
      logic [1:0] op = 2'b00;
      e.pc = pc; e.rd = w[4:0]; e.imm = 64'd0; e.illegal = 0;
      if (w[31:21] == 11'b10001011000 || w[31:21] == 11'b11001011000 ||
          w[31:21] == 11'b10001010000 || w[31:21] == 11'b10101010000) begin
         rw = 1; op = 2'b10;
      end else if (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1101000100) begin
         rw = 1; as = 1; op = 2'b10; e.imm = 64'(w[21:10]);
      end else if (w[31:21] == 11'b11111000010 || w[31:21] == 11'b11111000000) begin
         as = 1;
         if (w[22]) begin rw = 1; mr = 1; mtr = 1; end
         else begin mw = 1; r2l = 1; end
         v = longint'(w[20:12]);
         if (v >= 256) v -= 512;
         e.imm = 64'(v);
      end else if (w[31:24] == 8'b10110100) begin
         br = 1; r2l = 1; op = 2'b01;
         v = longint'(w[23:5]);
         if (v >= (64'd1 << 18)) v -= (64'd1 << 19);
         e.imm = 64'(v);
      end else if (w[31:26] == 6'b000101) begin
         ub = 1;
         v = longint'(w[25:0]);
         if (v >= (64'd1 << 25)) v -= (64'd1 << 26);
         e.imm = 64'(v);
      end else begin
         e.illegal = 1;
      end
      e.a    = regs[w[9:5]];
      e.b    = regs[r2l ? w[4:0] : w[20:16]];
      e.ctrl = {rw, mr, mw, mtr, as, br, ub, op};
      return e;
   endfunction

   function automatic logic [4:0] rsel();
      if ($urandom_range(0, 9) == 0) return 5'd31;
      return 5'($urandom_range(0, 7));
   endfunction

   function automatic logic [31:0] enc_r(input logic [10:0] opc, input logic [4:0] rm,
                                         input logic [4:0] rn, input logic [4:0] rd);
      return {opc, rm, 6'd0, rn, rd};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [4:0]  a, b, c;
      r = $urandom; a = rsel(); b = rsel(); c = rsel();
      case ($urandom_range(0, 11))
         0:  return enc_r(11'b10001011000, b, a, c);
         1:  return enc_r(11'b11001011000, b, a, c);
         2:  return enc_r(11'b10001010000, b, a, c);
         3:  return enc_r(11'b10101010000, b, a, c);
         4:  return {10'b1001000100, r[11:0], a, c};
         5:  return {10'b1101000100, r[11:0], a, c};
         6, 7: return {11'b11111000010, r[8:0], 2'b00, a, c};
         8:  return {11'b11111000000, r[8:0], 2'b00, a, c};
         9:  return {8'b10110100, r[18:0], c};
         10: return {6'b000101, r[25:0]};
         default: return r[0] ? 32'h0000_0000 : 32'hFFFF_FFFF;
      endcase
   endfunction

   // Acceptance side: every instruction the stage takes gets its expected result queued.
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         if (flush) begin
            q.delete();
            if (bus.in_valid) taken = 1'b1;
         end else if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.in_instr, bus.in_pc));
            taken = 1'b1;
         end
      end
   end

   // Monitor: compares each transfer to execute, illegal pulses and hold stability.
   bit         prev_valid = 0, prev_xfer = 0, held = 0, fresh;
   logic [270:0] snap, snap_now;
   exp_t       e;
   always @(negedge clk) begin
      #3;
      if (!rst_n) begin
         prev_valid = 0; prev_xfer = 0; held = 0;
      end else begin
         snap_now = {bus.out_valid, bus.out_pc, bus.out_a, bus.out_b, bus.out_imm,
                     bus.out_rd, bus.out_ctrl};
         if (held) begin
            checks++;
            if (snap_now !== snap) begin
               failures++;
               $display("FAIL hold_stable actual=%h expected=%h", snap_now, snap);
            end
         end
         if (bus.out_valid && !flush) begin
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_out actual pc=%h expected=none", bus.out_pc);
            end else begin
               fresh = !prev_valid || prev_xfer;
               chk("illegal_pulse", 64'(bus.illegal_instr), fresh ? 64'(q[0].illegal) : 64'd0);
               if (bus.out_ready) begin
                  e = q.pop_front();
                  checks++;
                  if ({bus.out_pc, bus.out_a, bus.out_b, bus.out_imm, bus.out_rd, bus.out_ctrl} !==
                      {e.pc, e.a, e.b, e.imm, e.rd, e.ctrl}) begin
                     failures++;
                     $display("FAIL xfer actual pc=%h a=%h b=%h imm=%h rd=%0d ctrl=%b expected pc=%h a=%h b=%h imm=%h rd=%0d ctrl=%b",
                              bus.out_pc, bus.out_a, bus.out_b, bus.out_imm, bus.out_rd, bus.out_ctrl,
                              e.pc, e.a, e.b, e.imm, e.rd, e.ctrl);
                  end else begin
                     $display("xfer pc=%h rd=%0d ctrl=%b imm=%h", e.pc, e.rd, e.ctrl, e.imm);
                  end
               end
            end
         end
         prev_valid = bus.out_valid;
         prev_xfer  = bus.out_valid && bus.out_ready;
         held       = bus.out_valid && !bus.out_ready && !flush;
         snap       = snap_now;
      end
   end

   logic [63:0] pc;
   logic [31:0] w1, w2;
   exp_t        m1;

   initial begin
      foreach (regs[i]) regs[i] = {$urandom, $urandom};
      regs[31] = 64'd0; regs[1] = 64'd10; regs[2] = 64'd20;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b1;

      // Reset state
      tick(); tick();
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_a", bus.out_a, 64'd0);
      chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
      chk("rst_illegal", 64'(bus.illegal_instr), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      rst_n = 1'b1;

      // ADD X3,X1,X2
      tick(); send(32'h8B02_0023, 64'h100);
      tick(); bus.in_valid = 1'b0;
      chk("add_rr1", 64'(rr1), 64'd1);
      chk("add_rr2", 64'(rr2), 64'd2);
      chk("add_latency", 64'(bus.out_valid), 64'd0);
      tick();
      chk("add_valid", 64'(bus.out_valid), 64'd1);
      chk("add_a", bus.out_a, 64'd10);
      chk("add_b", bus.out_b, 64'd20);
      chk("add_rd", 64'(bus.out_rd), 64'd3);
      chk("add_ctrl", 64'(bus.out_ctrl), 64'h102);

      // LDUR X5,[X2,#-8] then dependent ADD X6,X5,X1
      send(32'hF85F_8045, 64'h104);
      tick(); send(32'h8B01_00A6, 64'h108);
      tick(); bus.in_valid = 1'b0;
      chk("ldur_valid", 64'(bus.out_valid), 64'd1);
      chk("ldur_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("ldur_mem_read", 64'(bus.out_ctrl.mem_read), 64'd1);
      chk("hazard_rr1", 64'(rr1), 64'd5);
      chk("hazard_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      chk("bubble_valid", 64'(bus.out_valid), 64'd0);
      tick();
      chk("dep_valid", 64'(bus.out_valid), 64'd1);
      chk("dep_pc", bus.out_pc, 64'h108);
      chk("dep_a", bus.out_a, regs[5]);

      // STUR X7,[X4,#16]
      send(32'hF801_0087, 64'h10C);
      tick(); bus.in_valid = 1'b0;
      chk("stur_rr1", 64'(rr1), 64'd4);
      chk("stur_rr2", 64'(rr2), 64'd7);
      tick();
      chk("stur_imm", bus.out_imm, 64'd16);
      chk("stur_mem_write", 64'(bus.out_ctrl.mem_write), 64'd1);
      chk("stur_reg_write", 64'(bus.out_ctrl.reg_write), 64'd0);

      // Backpressure with two pending instructions
      w1 = enc_r(11'b10001011000, 5'd2, 5'd1, 5'd9);
      w2 = enc_r(11'b11001011000, 5'd3, 5'd4, 5'd10);
      m1 = model(w1, 64'h200);
      send(w1, 64'h200);
      tick(); send(w2, 64'h204);
      tick(); bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_pc", bus.out_pc, 64'h200);
         chk("bp_a", bus.out_a, m1.a);
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("bp_order", bus.out_pc, 64'h204);
      tick();

      // Flush with both slots full and a new instruction offered
      bus.out_ready = 1'b0;
      send(enc_r(11'b10001010000, 5'd1, 5'd2, 5'd11), 64'h300);
      tick(); send(enc_r(11'b10101010000, 5'd1, 5'd2, 5'd12), 64'h304);
      tick(); send(enc_r(11'b10001011000, 5'd1, 5'd2, 5'd13), 64'h308);
      flush = 1'b1;
      tick(); flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      chk("flush_valid", 64'(bus.out_valid), 64'd0);
      chk("flush_slot", 64'(bus.in_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("flush_dropped", 64'(bus.out_valid), 64'd0);
      end

      // Randomized traffic
      pc = 64'h1000; taken = 1'b0;
      for (int c = 0; c < 800; c++) begin
         if (!bus.in_valid || taken) begin
            taken = 1'b0;
            if ($urandom_range(0, 3) != 0) begin
               send(rand_instr(), pc);
               pc += 64'd4;
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 40) == 0);
         tick();
      end
      bus.in_valid = 1'b0; flush = 1'b0; bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) tick();
      tick();
      chk("drain", 64'(q.size()), 64'd0);

      // Illegal word, then asynchronous reset during a stall
      send(32'h0000_0000, 64'h400);
      tick(); send(32'h8B02_0023, 64'h404); bus.out_ready = 1'b0;
      tick(); bus.in_valid = 1'b0;
      chk("illegal_valid", 64'(bus.out_valid), 64'd1);
      chk("illegal_pulse_dir", 64'(bus.illegal_instr), 64'd1);
      chk("illegal_ctrl", 64'(bus.out_ctrl), 64'd0);
      tick();
      chk("illegal_one_cycle", 64'(bus.illegal_instr), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(bus.out_valid), 64'd0);
      chk("arst_pc", bus.out_pc, 64'd0);
      chk("arst_ctrl", 64'(bus.out_ctrl), 64'd0);
      q.delete();
      tick(); rst_n = 1'b1;
      tick();
      chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("arst_idle", 64'(bus.out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
